// File: rtl/sdac_serializer.sv
// Parallel-to-serial front end for the SDAC serial DAC.
// A one-entry holding register accepts samples over valid/ready. Each sample
// is shifted out MSB-first on SI with en high, followed by a one-cycle soc
// pulse and GAP idle cycles. All outputs come straight from registers.
module sdac_serializer #(
    parameter int WIDTH = 8,
    parameter int DIV   = 1,
    parameter int GAP   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             SI,
    output logic             en,
    output logic             soc,
    output logic             busy,
    output logic             underrun
);

    localparam int BW = $clog2(WIDTH + 1);
    localparam int DW = $clog2(DIV + 1);
    localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_SOC   = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    state_t             state_reg, state_next;
    logic [WIDTH-1:0]   shreg_reg, shreg_next;
    logic [BW-1:0]      bitcnt_reg, bitcnt_next;
    logic [DW-1:0]      divcnt_reg, divcnt_next;
    logic [GW-1:0]      gapcnt_reg, gapcnt_next;
    logic [WIDTH-1:0]   hold_reg, hold_next;
    logic               hold_full_reg, hold_full_next;
    logic               sent_any_reg, sent_any_next;
    logic               ready_reg;
    logic               si_reg, en_reg, soc_reg, busy_reg, underrun_reg;
    logic               underrun_next;
    logic               accept;
    logic               load;
    logic               frame_end;

    // Next-state logic: frame sequencing, holding-register bookkeeping
    always_comb begin
        state_next    = state_reg;
        shreg_next    = shreg_reg;
        bitcnt_next   = bitcnt_reg;
        divcnt_next   = divcnt_reg;
        gapcnt_next   = gapcnt_reg;
        sent_any_next = sent_any_reg;
        underrun_next = 1'b0;
        load          = 1'b0;
        frame_end     = 1'b0;
        accept        = din_valid && ready_reg;

        case (state_reg)
            S_IDLE: begin
                if (hold_full_reg) begin
                    load = 1'b1;
                end
            end
            S_SHIFT: begin
                if (divcnt_reg == DIV_LAST) begin
                    divcnt_next = '0;
                    shreg_next  = {shreg_reg[WIDTH-2:0], 1'b0};
                    bitcnt_next = bitcnt_reg + 1'b1;
                    if (bitcnt_reg == BIT_LAST) begin
                        state_next = S_SOC;
                    end
                end else begin
                    divcnt_next = divcnt_reg + 1'b1;
                end
            end
            S_SOC: begin
                sent_any_next = 1'b1;
                if (GAP > 0) begin
                    state_next  = S_GAP;
                    gapcnt_next = '0;
                end else begin
                    frame_end = 1'b1;
                end
            end
            S_GAP: begin
                if (gapcnt_reg == GAP_LAST) begin
                    frame_end = 1'b1;
                end else begin
                    gapcnt_next = gapcnt_reg + 1'b1;
                end
            end
            default: state_next = S_IDLE;
        endcase

        // A held sample starts the next frame immediately; otherwise the slot was missed.
        if (frame_end) begin
            if (hold_full_reg) begin
                load = 1'b1;
            end else begin
                state_next    = S_IDLE;
                underrun_next = sent_any_next;
            end
        end

        if (load) begin
            state_next  = S_SHIFT;
            shreg_next  = hold_reg;
            bitcnt_next = '0;
            divcnt_next = '0;
        end

        // An accept on the load edge refills the register, so it stays full.
        hold_full_next = accept ? 1'b1 : (load ? 1'b0 : hold_full_reg);
        hold_next      = accept ? din : hold_reg;
    end

    // State and datapath registers; outputs registered from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            shreg_reg     <= '0;
            bitcnt_reg    <= '0;
            divcnt_reg    <= '0;
            gapcnt_reg    <= '0;
            hold_reg      <= '0;
            hold_full_reg <= 1'b0;
            sent_any_reg  <= 1'b0;
            ready_reg     <= 1'b0;
            si_reg        <= 1'b0;
            en_reg        <= 1'b0;
            soc_reg       <= 1'b0;
            busy_reg      <= 1'b0;
            underrun_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            shreg_reg     <= shreg_next;
            bitcnt_reg    <= bitcnt_next;
            divcnt_reg    <= divcnt_next;
            gapcnt_reg    <= gapcnt_next;
            hold_reg      <= hold_next;
            hold_full_reg <= hold_full_next;
            sent_any_reg  <= sent_any_next;
            ready_reg     <= !hold_full_next;
            si_reg        <= (state_next == S_SHIFT) ? shreg_next[WIDTH-1] : 1'b0;
            en_reg        <= (state_next == S_SHIFT);
            soc_reg       <= (state_next == S_SOC);
            busy_reg      <= (state_next != S_IDLE);
            underrun_reg  <= underrun_next;
        end
    end

    assign din_ready = ready_reg;
    assign SI        = si_reg;
    assign en        = en_reg;
    assign soc       = soc_reg;
    assign busy      = busy_reg;
    assign underrun  = underrun_reg;

endmodule

// File: tb/tb_sdac_serializer.sv
// Testbench for sdac_serializer: three instances (DIV/GAP = 1/2, 4/2, 1/0)
// compared every cycle against a frame-position model, plus directed checks.
module tb_sdac_serializer;

    localparam int N = 3;
    localparam int W = 8;
    localparam int DIVS[N] = '{1, 4, 1};
    localparam int GAPS[N] = '{2, 2, 0};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] din[N];
    logic       din_valid[N];
    logic       din_ready[N];
    logic       si[N];
    logic       en[N];
    logic       soc[N];
    logic       busy[N];
    logic       underrun[N];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic chk_en = 1'b0;
    logic acc_flag[N];

    // model state
    logic       m_active[N];
    int         m_pos[N];
    logic [7:0] m_data[N];
    logic [7:0] m_hold[N];
    logic       m_hold_full[N];
    logic       m_ready[N];
    logic       m_under[N];

    always #5 clk = ~clk;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_dut
            sdac_serializer #(
                .WIDTH(W),
                .DIV(DIVS[gi]),
                .GAP(GAPS[gi])
            ) u_dut (
                .clk(clk),
                .rst(rst),
                .din(din[gi]),
                .din_valid(din_valid[gi]),
                .din_ready(din_ready[gi]),
                .SI(si[gi]),
                .en(en[gi]),
                .soc(soc[gi]),
                .busy(busy[gi]),
                .underrun(underrun[gi])
            );
        end
    endgenerate

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s t=%0d actual=%0h required=%0h", name, cyc, act, req);
        end
    endtask

    always @(posedge clk) cyc++;

    // transfer monitor: one line per accepted sample
    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            acc_flag[i] = !rst && din_valid[i] && din_ready[i];
            if (acc_flag[i])
                $display("xfer inst=%0d cyc=%0d din=%02h", i, cyc, din[i]);
        end
    end

    // Model: each frame occupies W*DIV+1+GAP slots; position p within the frame
    // decides the outputs. A held sample starts a frame at the end of the
    // previous one (or at once when idle); no sample at frame end is an underrun.
    always @(posedge clk) begin
        int   len;
        logic acc;
        logic load;
        for (int i = 0; i < N; i++) begin
            len = W * DIVS[i] + 1 + GAPS[i];
            if (rst) begin
                m_active[i]    = 1'b0;
                m_pos[i]       = 0;
                m_hold_full[i] = 1'b0;
                m_ready[i]     = 1'b0;
                m_under[i]     = 1'b0;
            end else begin
                acc        = din_valid[i] && m_ready[i];
                load       = 1'b0;
                m_under[i] = 1'b0;
                if (!m_active[i]) begin
                    if (m_hold_full[i]) load = 1'b1;
                end else if (m_pos[i] == len - 1) begin
                    if (m_hold_full[i]) load = 1'b1;
                    else begin
                        m_active[i] = 1'b0;
                        m_under[i]  = 1'b1;
                    end
                end else begin
                    m_pos[i] = m_pos[i] + 1;
                end
                if (load) begin
                    m_active[i] = 1'b1;
                    m_pos[i]    = 0;
                    m_data[i]   = m_hold[i];
                end
                if (acc) begin
                    m_hold_full[i] = 1'b1;
                    m_hold[i]      = din[i];
                end else if (load) begin
                    m_hold_full[i] = 1'b0;
                end
                m_ready[i] = !m_hold_full[i];
            end
        end
    end

    // Compare every instance against the model on the falling edge
    always @(negedge clk) begin
        int   d;
        logic e_en;
        logic e_si;
        logic e_soc;
        if (chk_en) begin
            for (int i = 0; i < N; i++) begin
                d     = DIVS[i];
                e_en  = m_active[i] && (m_pos[i] < W * d);
                e_si  = e_en ? m_data[i][7 - m_pos[i] / d] : 1'b0;
                e_soc = m_active[i] && (m_pos[i] == W * d);
                chk($sformatf("m%0d_si", i), si[i], e_si);
                chk($sformatf("m%0d_en", i), en[i], e_en);
                chk($sformatf("m%0d_soc", i), soc[i], e_soc);
                chk($sformatf("m%0d_busy", i), busy[i], m_active[i]);
                chk($sformatf("m%0d_underrun", i), underrun[i], m_under[i]);
                chk($sformatf("m%0d_ready", i), din_ready[i], m_ready[i]);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer v on instance i and return #1 after the accepting edge.
    task automatic put(input int i, input logic [7:0] v);
        int n;
        n = 0;
        din[i] = v;
        din_valid[i] = 1'b1;
        while (din_ready[i] !== 1'b1 && n < 100) begin
            step();
            n++;
        end
        chk($sformatf("put%0d_wait", i), n < 100, 1);
        step();
        din_valid[i] = 1'b0;
    endtask

    task automatic wait_soc(input int i, output int t);
        int n;
        n = 0;
        while (soc[i] !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        chk($sformatf("soc%0d_wait", i), n < 200, 1);
        t = cyc;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog t=%0d actual=timeout required=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic a5_bits[8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        int   t1, t2, t3;
        int   rate;

        for (int i = 0; i < N; i++) begin
            din[i] = 8'h3C;
            din_valid[i] = 1'b1;
        end

        // reset held 3 cycles with valid asserted
        rst = 1'b1;
        repeat (3) begin
            step();
            chk_en = 1'b1;
            chk("rst_ready", din_ready[0], 0);
            chk("rst_si", si[0], 0);
            chk("rst_en", en[0], 0);
            chk("rst_soc", soc[0], 0);
            chk("rst_busy", busy[0], 0);
            chk("rst_underrun", underrun[0], 0);
        end
        rst = 1'b0;
        for (int i = 0; i < N; i++) din_valid[i] = 1'b0;
        step();
        for (int i = 0; i < N; i++) chk($sformatf("rel_ready%0d", i), din_ready[i], 1);

        // single sample A5
        put(0, 8'hA5);
        for (int k = 0; k < 8; k++) begin
            step();
            chk($sformatf("a5_si%0d", k), si[0], a5_bits[k]);
            chk("a5_en", en[0], 1);
        end
        step();
        chk("a5_soc", soc[0], 1);
        chk("a5_soc_en", en[0], 0);
        repeat (2) begin
            step();
            chk("a5_gap_soc", soc[0], 0);
            chk("a5_gap_busy", busy[0], 1);
        end
        step();
        chk("a5_underrun", underrun[0], 1);
        chk("a5_idle_busy", busy[0], 0);
        step();
        chk("a5_underrun_end", underrun[0], 0);
        repeat (5) step();

        // stream 00 then FF
        put(0, 8'h00);
        put(0, 8'hFF);
        chk("strm_ready_full", din_ready[0], 0);
        wait_soc(0, t1);
        wait_soc(0, t2);
        chk("strm_period", t2 - t1, 11);
        repeat (20) step();

        // DIV=4, sample 81
        put(1, 8'h81);
        for (int c = 0; c < 32; c++) begin
            step();
            chk($sformatf("d4_si%0d", c), si[1], (c < 4 || c >= 28) ? 1 : 0);
            chk("d4_en", en[1], 1);
        end
        step();
        chk("d4_soc", soc[1], 1);
        repeat (20) step();

        // reset during bit 4 of F0
        put(0, 8'hF0);
        repeat (5) step();
        chk("f0_bit4_si", si[0], 0);
        chk("f0_bit4_en", en[0], 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_si", si[0], 0);
        chk("abort_en", en[0], 0);
        chk("abort_busy", busy[0], 0);
        repeat (15) begin
            step();
            chk("abort_nosoc", soc[0], 0);
        end
        put(0, 8'h3C);
        step();
        chk("post_b0", si[0], 0);
        step();
        chk("post_b1", si[0], 0);
        step();
        chk("post_b2", si[0], 1);
        repeat (20) step();

        // GAP=0 continuous 55
        din[2] = 8'h55;
        din_valid[2] = 1'b1;
        wait_soc(2, t1);
        wait_soc(2, t2);
        wait_soc(2, t3);
        chk("g0_period1", t2 - t1, 9);
        chk("g0_period2", t3 - t2, 9);
        din_valid[2] = 1'b0;
        repeat (30) step();

        // randomized traffic, high then low offered load, rare resets
        for (int c = 0; c < 3000; c++) begin
            rate = (c < 1500) ? 90 : 30;
            rst = ($urandom_range(0, 999) == 0);
            for (int i = 0; i < N; i++) begin
                if (!din_valid[i] || acc_flag[i]) begin
                    din_valid[i] = ($urandom_range(0, 99) < rate);
                    din[i] = 8'($urandom);
                end
            end
            step();
        end
        rst = 1'b0;
        for (int i = 0; i < N; i++) din_valid[i] = 1'b0;
        repeat (60) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
